// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums every n signed products into a saturated dot-product result held on a valid/ready output
module booth_product_accumulator #(
  parameter int x = 4,
  parameter int y = 4,
  parameter int n = 4,
  parameter int g = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [x+y-1:0]       p_in,
  input  logic                 p_valid,
  output logic                 p_ready,
  output logic [x+y+g-1:0]     acc_out,
  output logic                 acc_ovf,
  output logic                 acc_valid,
  input  logic                 acc_ready
);
  localparam int W = x + y + g;
  localparam int CW = n > 1 ? $clog2(n) : 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [W-1:0] acc, res;
  logic [W:0] s;
  logic [CW-1:0] cnt;
  logic ovf, sat, accept, last;
  assign p_ready = state == ACCUM;
  assign acc_valid = state == HOLD;
  assign accept = p_valid && p_ready;
  assign last = cnt == CW'(n - 1);
  // one extra bit exposes overflow as a disagreement between the top two sum bits
  assign s = {acc[W-1], acc} + {{(g + 1){p_in[x+y-1]}}, p_in};
  assign sat = s[W] ^ s[W-1];
  assign res = sat ? (s[W] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}}) : s[W-1:0];
  always_comb begin
    state_nx = state;
    if (clr) state_nx = ACCUM;
    else if (state == ACCUM) state_nx = accept && last ? HOLD : ACCUM;
    else state_nx = acc_ready ? ACCUM : HOLD;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      acc_out <= '0;
      acc_ovf <= 1'b0;
    end else if (accept && last) begin
      acc_out <= res;
      acc_ovf <= ovf | sat;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= res;
      cnt <= cnt + CW'(1);
      ovf <= ovf | sat;
    end
  end
endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream stage of the Booth multiplier. Accepts a stream of signed products over a valid/ready handshake and sums every `n` consecutive products into one dot-product result. Each sum is saturated to the accumulator width, and a per-group overflow flag is set when saturation occurs. The finished result is held on a valid/ready output until the consumer takes it.

## Interface
- `x`, 4, multiplicand width parameter of the upstream multiplier.
- `y`, 4, multiplier width parameter of the upstream multiplier.
- `n`, 4, products per group (≥1).
- `g`, 4, guard bits. Accumulator width W = x+y+g.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear. Discards the partial group and any held result.
- `p_in`  in  x+y  signed product from the multiplier (`P_final`).
- `p_valid`  in  1  `p_in` is valid.
- `p_ready`  out  1  block can accept a product this cycle.
- `acc_out`  out  W  signed group sum.
- `acc_ovf`  out  1  saturation occurred at least once in this group.
- `acc_valid`  out  1  `acc_out` and `acc_ovf` are valid.
- `acc_ready`  in  1  consumer accepts the result.

## Operation
- Two states:
  - ACCUM: `p_ready`=1, `acc_valid`=0.
  - HOLD: `p_ready`=0, `acc_valid`=1.
- Internal registers:
  - `acc` (W bits, signed).
  - `cnt` (0..n-1, width clog2(n), minimum 1).
  - `ovf` (sticky).
- A beat is accepted when `p_valid && p_ready`.
- Sum rule: `s` = `acc` + sign-extend(`p_in`), computed at W+1 bits.
  - If `s[W]` ≠ `s[W-1]`, the result saturates: to 2^(W-1)-1 if `s[W]`=0, otherwise to -2^(W-1). `ovf` is set.
  - Otherwise the result is `s[W-1:0]`.
- Accepted beat in ACCUM with `cnt` < n-1:
  - `acc` ← result; `cnt` ← `cnt`+1; `ovf` stays set if already set.
- Accepted beat in ACCUM with `cnt` = n-1:
  - `acc_out` ← result; `acc_ovf` ← `ovf` OR this beat's saturation.
  - `acc` ← 0, `cnt` ← 0, `ovf` ← 0.
  - State → HOLD.
- HOLD:
  - `acc_out` and `acc_ovf` stay stable until `acc_valid && acc_ready`.
  - On that handshake, state → ACCUM.
  - `p_in` is ignored; no beat is accepted.
- `clr`:
  - Zeroes `acc`, `cnt`, `ovf`, `acc_out` and `acc_ovf`.
  - State → ACCUM.
  - Overrides any beat or output handshake in the same cycle; the beat is dropped, not counted.
- n=1: every accepted beat goes straight to HOLD with `acc_out` = sign-extended `p_in`. Saturation is impossible when g≥0.
- `rst` (asynchronous, any time, including mid-group or in HOLD):
  - State ACCUM, so `p_ready`=1 and `acc_valid`=0.
  - `acc_out`=0, `acc_ovf`=0.
  - `acc`=0, `cnt`=0, `ovf`=0.
  - The first rising edge after deassertion can accept a beat.

## Timing
- `p_ready` and `acc_valid` are decoded from the registered state only. No combinational path exists from `p_valid` or `acc_ready`.
- Latency: `acc_valid` rises on the edge that accepts the n-th beat, so it is visible in the following cycle.
- Throughput with `acc_ready` tied high: n accept cycles plus 1 HOLD cycle per group. `p_ready` is low for exactly one cycle between groups.
- With `acc_ready` low, HOLD lasts indefinitely. Upstream sees `p_ready`=0 and must hold `p_in`/`p_valid`.
- `p_valid` gaps in ACCUM stall counting without changing `acc` or `cnt`.
- `acc_out` is registered. It changes only on entry to HOLD, on `clr`, or on `rst`.

## Test plan
- Group sum (x=y=4, n=4, g=4; `acc_ready`=1): beats 3, -5, 7, 2 on consecutive cycles → `acc_valid` for 1 cycle with `acc_out`=7 and `acc_ovf`=0; `p_ready` low that cycle, high the next.
- Backpressure: same beats, `acc_ready` held 0 for 5 cycles → `acc_out`=7 stable and `p_ready`=0 throughout; beats presented meanwhile are not consumed. Raising `acc_ready` → ACCUM next cycle; the next group of 1, 1, 1, 1 gives 4.
- Saturation (g=1, W=9): beats 127, 127, 127, 127 → `acc_out`=255, `acc_ovf`=1. Then -128 ×4 → `acc_out`=-256, `acc_ovf`=1. Then 1, 1, 1, 1 → `acc_out`=4, `acc_ovf`=0 (the flag does not leak into the next group).
- Valid gaps: 10, idle, idle, -3, idle, 5, 1 → single result 13 after the 4th accepted beat.
- `clr` mid-group: 2 beats of 9, then `clr` together with `p_valid` carrying 9, then 1, 2, 3, 4 → result 10; the 9s are discarded. `clr` in HOLD → `acc_valid` drops next cycle and `acc_out`=0.
- `rst` asserted asynchronously mid-cycle after 3 beats → `acc_valid`=0, `p_ready`=1 and `acc_out`=0 immediately. After release, beats 1, 1, 1, 1 → 4.
